// File: rtl/dff_sched_pkg.sv
// Shared types for the flip-flop bank scheduler: bank command encoding and FSM states.
package dff_sched_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_PRESET = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    DRIVE,
    ACK
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_scheduler.sv
// Round-robin scheduler driving a DFF bank's enable/data/preset/clear pins, one command at a time.
// Optional macro DFF_SCHED_PRIO_EN gives requester 0 fixed priority over the round-robin.
module dff_bank_scheduler
  import dff_sched_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int N_REGS = 4,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(N_REGS),
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0][1:0]         op,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              ack,
  output logic                          err,
  output logic [DATA_W-1:0]             bank_d,
  output logic [N_REGS-1:0]             bank_en,
  output logic [N_REGS-1:0]             bank_clr_n,
  output logic [N_REGS-1:0]             bank_pre_n,
  output logic                          busy
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      win_q, win_d;
  op_e                 op_q, op_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   bd_q, bd_d;
  logic [N_REGS-1:0]   en_q, en_d, clr_q, clr_d, pre_q, pre_d;

  logic [N_REQ-1:0]    a_gnt;
  logic [IDW-1:0]      a_idx, sel_idx;
  logic                a_vld;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (a_gnt),
    .idx_o (a_idx),
    .vld_o (a_vld)
  );

`ifdef DFF_SCHED_PRIO_EN
  assign sel_idx = req[0] ? '0 : a_idx;
`else
  assign sel_idx = a_idx;
`endif
  assign sel_addr = addr[sel_idx];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    op_d    = op_q;
    ack_d   = '0;
    err_d   = 1'b0;
    bd_d    = '0;
    en_d    = '0;
    clr_d   = '1;
    pre_d   = '1;
    unique case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (a_vld) begin
          // Bank pins are loaded here so they are registered and valid for the whole DRIVE cycle.
          win_d   = sel_idx;
          op_d    = op_e'(op[sel_idx]);
          state_d = DRIVE;
          unique case (op_d)
            OP_LOAD: begin
              en_d[sel_addr] = 1'b1;
              bd_d           = wdata[sel_idx];
            end
            OP_CLEAR:  clr_d[sel_addr] = 1'b0;
            OP_PRESET: pre_d[sel_addr] = 1'b0;
            default: ;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        state_d      = ACK;
        ack_d[win_q] = 1'b1;
        err_d        = (op_q == OP_RSVD);
      end
      ACK: begin
        state_d = IDLE;
`ifdef DFF_SCHED_PRIO_EN
        if (win_q != '0)
`endif
          rr_d = (win_q == IDW'(N_REQ-1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      op_q    <= OP_LOAD;
      ack_q   <= '0;
      err_q   <= 1'b0;
      bd_q    <= '0;
      en_q    <= '0;
      clr_q   <= '1;
      pre_q   <= '1;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      bd_q    <= bd_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      pre_q   <= pre_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign bank_d     = bd_q;
  assign bank_en    = en_q;
  assign bank_clr_n = clr_q;
  assign bank_pre_n = pre_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dff_bank_scheduler.sv
// Directed bench for dff_bank_scheduler (4 requesters, 4 x 8-bit registers).
module tb_dff_bank_scheduler;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][1:0] op;
  logic [3:0][1:0] addr;
  logic [3:0][7:0] wdata;
  logic [3:0]      ack;
  logic            err;
  logic [7:0]      bank_d;
  logic [3:0]      bank_en, bank_clr_n, bank_pre_n;
  logic            busy;

  int tests = 0;
  int fails = 0;

  dff_bank_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .err        (err),
    .bank_d     (bank_d),
    .bank_en    (bank_en),
    .bank_clr_n (bank_clr_n),
    .bank_pre_n (bank_pre_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n);
    n = 0;
    a = '0;
    while (n < 20 && a == 4'b0) begin
      tick();
      n++;
      a = ack;
    end
  endtask

  logic [3:0] a;
  int         n;
  logic [3:0] exp_ack;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    addr  = '0;
    wdata = '0;
    #12;
    chk("rst_ack",  32'(ack), 32'h0);
    chk("rst_err",  32'(err), 32'h0);
    chk("rst_d",    32'(bank_d), 32'h0);
    chk("rst_en",   32'(bank_en), 32'h0);
    chk("rst_clr",  32'(bank_clr_n), 32'hf);
    chk("rst_pre",  32'(bank_pre_n), 32'hf);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // single load from requester 1
    req = 4'b0010; op[1] = 2'b00; addr[1] = 2'd3; wdata[1] = 8'ha5;
    tick();
    chk("ld_arb_busy", 32'(busy), 32'h1);
    chk("ld_arb_en",   32'(bank_en), 32'h0);
    tick();
    chk("ld_drv_en",   32'(bank_en), 32'h8);
    chk("ld_drv_d",    32'(bank_d), 32'ha5);
    chk("ld_drv_ack",  32'(ack), 32'h0);
    tick();
    chk("ld_ack",      32'(ack), 32'h2);
    chk("ld_err",      32'(err), 32'h0);
    chk("ld_ack_en",   32'(bank_en), 32'h0);
    chk("ld_ack_d",    32'(bank_d), 32'h0);
    req = '0;
    tick();
    chk("ld_idle_busy", 32'(busy), 32'h0);
    chk("ld_idle_ack",  32'(ack), 32'h0);

    // round-robin with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op[i] = 2'b00; addr[i] = 2'(i); wdata[i] = 8'(8'h10 + i);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, n);
      exp_ack = 4'b0001 << (k % 4);
      chk($sformatf("rr_ack%0d", k), 32'(a), 32'(exp_ack));
      chk($sformatf("rr_gap%0d", k), 32'(n), (k == 0) ? 32'd3 : 32'd4);
      chk($sformatf("rr_en%0d", k),  32'(bank_en), 32'h0);
    end
    req = '0;
    tick();
    chk("rr_idle", 32'(busy), 32'h0);

    // clear then preset register 1 from requester 2
    req = 4'b0100; op[2] = 2'b01; addr[2] = 2'd1;
    tick(); tick();
    chk("clr_drv",     32'(bank_clr_n), 32'hd);
    chk("clr_drv_pre", 32'(bank_pre_n), 32'hf);
    chk("clr_drv_en",  32'(bank_en), 32'h0);
    tick();
    chk("clr_ack",     32'(ack), 32'h4);
    chk("clr_rel",     32'(bank_clr_n), 32'hf);
    req = '0;
    tick();
    req = 4'b0100; op[2] = 2'b10;
    tick(); tick();
    chk("pre_drv",     32'(bank_pre_n), 32'hd);
    chk("pre_drv_clr", 32'(bank_clr_n), 32'hf);
    tick();
    chk("pre_ack",     32'(ack), 32'h4);
    chk("pre_rel",     32'(bank_pre_n), 32'hf);
    req = '0;
    tick();

    // reserved op from requester 3
    req = 4'b1000; op[3] = 2'b11; addr[3] = 2'd0; wdata[3] = 8'hff;
    tick(); tick();
    chk("rsv_en",   32'(bank_en), 32'h0);
    chk("rsv_clr",  32'(bank_clr_n), 32'hf);
    chk("rsv_pre",  32'(bank_pre_n), 32'hf);
    chk("rsv_d",    32'(bank_d), 32'h0);
    chk("rsv_busy", 32'(busy), 32'h1);
    tick();
    chk("rsv_ack",  32'(ack), 32'h8);
    chk("rsv_err",  32'(err), 32'h1);
    req = '0;
    tick();
    chk("rsv_err_clr", 32'(err), 32'h0);

    // request withdrawn before arbitration: back to IDLE, no ack
    req = 4'b0001; op[0] = 2'b00; addr[0] = 2'd2; wdata[0] = 8'h3c;
    tick();
    req = '0;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_en",   32'(bank_en), 32'h0);
    tick();
    chk("abort_ack",  32'(ack), 32'h0);

    // asynchronous reset in the middle of a DRIVE cycle
    req = 4'b0100; op[2] = 2'b01; addr[2] = 2'd2;
    tick(); tick();
    chk("mid_drv_clr", 32'(bank_clr_n), 32'hb);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("mid_rst_clr",  32'(bank_clr_n), 32'hf);
    chk("mid_rst_ack",  32'(ack), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_rst_noack", 32'(ack), 32'h0);

    // pointer at 2 with requesters 0 and 2 pending
    do_reset();
    req = 4'b0010; op[1] = 2'b00; addr[1] = 2'd0; wdata[1] = 8'h11;
    wait_ack(a, n);
    chk("p_setup", 32'(a), 32'h2);
    req = '0;
    tick();
    op[0] = 2'b00; op[1] = 2'b00; op[2] = 2'b00;
    req = 4'b0101;
    wait_ack(a, n);
`ifdef DFF_SCHED_PRIO_EN
    chk("p_first", 32'(a), 32'h1);
    req = 4'b0110;
    wait_ack(a, n);
    chk("p_second", 32'(a), 32'h4);
`else
    chk("p_first", 32'(a), 32'h4);
    req = 4'b0011;
    wait_ack(a, n);
    chk("p_wrap", 32'(a), 32'h1);
`endif
    req = '0;
    tick(); tick();
    chk("end_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_bank_scheduler.md
Name: dff_bank_scheduler

Overview:
- Arbitrates and sequences access to a bank of N_REGS DATA_W-bit D flip-flop registers with active-low preset/clear.
- N_REQ requesters issue load, clear or preset commands over a req/ack handshake.
- The block grants one requester at a time, round-robin, and drives the bank's enable, data and preset/clear lines for exactly one cycle per command.
- It sits between requester logic and the flip-flop bank and is the only driver of the bank's control pins.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- N_REGS, 4, number of registers in the bank (power of 2, ≥2)
- DATA_W, 8, register width
- ADDR_W, $clog2(N_REGS), derived localparam; not overridable

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level
- op  in  2*N_REQ  per-requester command: 00 load, 01 clear, 10 preset, 11 reserved
- addr  in  ADDR_W*N_REQ  per-requester target register
- wdata  in  DATA_W*N_REQ  per-requester load data
- ack  out  N_REQ  one-cycle completion pulse
- err  out  1  valid with ack; command rejected
- bank_d  out  DATA_W  data to bank D inputs
- bank_en  out  N_REGS  one-hot load enable
- bank_clr_n  out  N_REGS  per-register clear, active low
- bank_pre_n  out  N_REGS  per-register preset, active low
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - ack=0, err=0, bank_d=0, bank_en=0, busy=0
  - bank_clr_n and bank_pre_n all ones
  - FSM in IDLE, rr_ptr=0
- FSM states: IDLE, ARB, DRIVE, ACK.
- IDLE -> ARB when any req bit is 1.
- ARB:
  - Select the first set req at or after rr_ptr, wrapping from N_REQ-1 to 0.
  - Latch the winner's id, op, addr and wdata.
  - Go to DRIVE.
  - If req fell to all-zero since IDLE, return to IDLE with no ack.
- DRIVE, exactly one cycle, registered outputs:
  - load: bank_en[addr]=1, bank_d=wdata.
  - clear: bank_clr_n[addr]=0.
  - preset: bank_pre_n[addr]=0.
  - Only the addressed register is touched.
  - clr_n and pre_n are never low simultaneously for any register.
  - Then go to ACK.
- ACK:
  - ack[winner]=1 for one cycle; all bank controls return to idle values.
  - rr_ptr = winner+1 mod N_REQ.
  - Go to IDLE.
- Latency: req sampled in cycle 0 gives DRIVE in cycle 2 and ack in cycle 3. Minimum 4 cycles per command; back-to-back commands go ACK->IDLE->ARB.
- Handshake: a requester holds req, op, addr and wdata stable until ack. It drops req in the cycle after ack or the same command is reissued. Commands are latched in ARB; later changes are ignored.
- Error cases:
  - op=11 is rejected: no bank activity in DRIVE; ack with err=1.
  - Out-of-range addr cannot occur, since N_REGS is a power of 2.
- Fairness: any continuously requesting requester is served within N_REQ grants.
- Reset mid-operation: all bank controls return immediately (asynchronously) to idle values, with no partial pulse held. Any pending ack is lost and the requester must reissue.

Optional Feature:
- Macro: DFF_SCHED_PRIO_EN.
- Defined: requester 0 has fixed priority. If req[0]=1 in ARB, it wins regardless of rr_ptr, and rr_ptr is not updated when requester 0 wins. Remaining requesters stay round-robin.
- Undefined: pure round-robin for all requesters.

Decomposition:
- Shared package dff_sched_pkg holds:
  - op_e enum: OP_LOAD=2'b00, OP_CLEAR=2'b01, OP_PRESET=2'b10, OP_RSVD=2'b11
  - state_e enum: IDLE, ARB, DRIVE, ACK
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any-valid.
  - Purely combinational, reusable.
- Top-level holds the FSM, command latch, pointer and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE of a clear to addr 2 -> bank_clr_n=4'b1111 immediately; ack=0, busy=0.
- Single load: req[1]=1, op=00, addr=3, wdata=8'hA5 -> cycle 2: bank_en=4'b1000, bank_d=8'hA5; cycle 3: ack=4'b0010, err=0.
- Round-robin: req=4'b1111 held with re-raise after each ack -> grant order 0,1,2,3,0; each ack 4 cycles apart.
- Clear/preset: req[2] clear addr 1, then preset addr 1 -> bank_clr_n=4'b1101 for one cycle, later bank_pre_n=4'b1101 for one cycle; never both low.
- Reserved op: req[3]=1, op=11 -> no bank activity; ack[3]=1 with err=1.
- With DFF_SCHED_PRIO_EN: rr_ptr=2, req=4'b0101 -> requester 0 wins; rr_ptr stays 2; next grant goes to requester 2.
